// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and default memory watchdog limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_t;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int WAIT_W          = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent frozen on the data memory handshake.
// Flags expiry once the count reaches the watchdog limit.
module mem_wait_timer
  import hazard_pkg::*;
#(
  parameter int LIMIT = MEM_TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == WAIT_W'(LIMIT));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rd,
  input  logic        MEM_BranchTaken,
  input  logic        MEM_Jump,
  input  logic        MEM_MemAccess,
  input  logic        DMem_Ready,
  output logic        DMem_Req,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        EX_MEM_Write,
  output logic        MEM_WB_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        Redirect,
  output logic        Fault,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  hz_state_t state;
  logic in_wait, in_fault, load_use;
  logic freeze, redir, lu_stall, expired;

  assign in_wait  = (state == MEM_WAIT);
  assign in_fault = (state == FAULT);

  assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                    ((EX_Rd == ID_Rs) ||
                     (ID_UsesRt && (EX_Rd == ID_Rt)));

  // A held access in MEM_WAIT keeps freezing regardless of MEM_MemAccess
  assign freeze   = (state == RUN && MEM_MemAccess && !DMem_Ready) ||
                    (in_wait && !DMem_Ready);
  assign redir    = !in_fault && !freeze &&
                    (MEM_BranchTaken || MEM_Jump);
  assign lu_stall = !in_fault && !freeze && !redir && load_use;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (!freeze),
    .inc    (freeze),
    .expired(expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (MEM_MemAccess && !DMem_Ready) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (DMem_Ready)   state <= RUN;
          else if (expired) state <= FAULT;
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    DMem_Req     = 1'b0;
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    EX_MEM_Write = 1'b0;
    MEM_WB_Write = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    Redirect     = 1'b0;
    Fault        = 1'b0;
    if (Rst) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (in_fault) begin
      Fault = 1'b1;
    end else if (freeze) begin
      DMem_Req = 1'b1;
    end else begin
      DMem_Req     = in_wait || MEM_MemAccess;
      PC_Write     = !lu_stall;
      IF_ID_Write  = !lu_stall;
      EX_MEM_Write = 1'b1;
      MEM_WB_Write = 1'b1;
      Redirect     = redir;
      IF_ID_Flush  = redir;
      ID_EX_Flush  = redir || lu_stall;
      EX_MEM_Flush = redir;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((freeze || lu_stall) && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redir && flush_q != '1)                flush_q <= flush_q + 1'b1;
    end
  end

  assign StallCycles = Rst ? '0 : stall_q;
  assign FlushCount  = Rst ? '0 : flush_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model.
// Counter expectations follow HAZARD_PERF_EN as compiled.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
  logic        ID_UsesRt, EX_MemRead;
  logic        MEM_BranchTaken, MEM_Jump, MEM_MemAccess, DMem_Ready;
  logic        DMem_Req, PC_Write, IF_ID_Write, EX_MEM_Write, MEM_WB_Write;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Redirect, Fault;
  logic [31:0] StallCycles, FlushCount;

  int checks = 0;
  int errors = 0;

  int     mdl_wait  = 0;
  bit     mdl_fault = 1'b0;
  longint mdl_stall = 0;
  longint mdl_flush = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(T)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .EX_MemRead     (EX_MemRead),
    .EX_Rd          (EX_Rd),
    .MEM_BranchTaken(MEM_BranchTaken),
    .MEM_Jump       (MEM_Jump),
    .MEM_MemAccess  (MEM_MemAccess),
    .DMem_Ready     (DMem_Ready),
    .DMem_Req       (DMem_Req),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .EX_MEM_Write   (EX_MEM_Write),
    .MEM_WB_Write   (MEM_WB_Write),
    .IF_ID_Flush    (IF_ID_Flush),
    .ID_EX_Flush    (ID_EX_Flush),
    .EX_MEM_Flush   (EX_MEM_Flush),
    .Redirect       (Redirect),
    .Fault          (Fault),
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic bit m_frozen();
    return (mdl_wait > 0 || MEM_MemAccess) && !DMem_Ready;
  endfunction

  function automatic bit m_redir();
    return !m_frozen() && (MEM_BranchTaken || MEM_Jump);
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = EX_MemRead && EX_Rd != 0 &&
          (EX_Rd == ID_Rs || (ID_UsesRt && EX_Rd == ID_Rt));
    return !m_frozen() && !(MEM_BranchTaken || MEM_Jump) && hit;
  endfunction

  // {Req, PCW, IFIDW, EXMEMW, MEMWBW, IFIDF, IDEXF, EXMEMF, Redirect, Fault}
  function automatic logic [9:0] expect_vec();
    bit r, l, q;
    if (Rst)       return 10'b0_0000_111_0_0;
    if (mdl_fault) return 10'b0_0000_000_0_1;
    if (m_frozen()) return 10'b1_0000_000_0_0;
    r = m_redir();
    l = m_lu();
    q = (mdl_wait > 0) || MEM_MemAccess;
    return {q, !l, !l, 1'b1, 1'b1, r, r | l, r, r, 1'b0};
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      mdl_wait  = 0;
      mdl_fault = 1'b0;
      mdl_stall = 0;
      mdl_flush = 0;
    end else if (!mdl_fault) begin
      if (m_frozen() || m_lu()) mdl_stall++;
      if (m_redir())            mdl_flush++;
      if (mdl_wait > 0) begin
        if (DMem_Ready) mdl_wait = 0;
        else if (mdl_wait == T) begin
          mdl_fault = 1'b1;
          mdl_wait  = 0;
        end else mdl_wait++;
      end else if (MEM_MemAccess && !DMem_Ready) begin
        mdl_wait = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    logic [9:0]  got, exp;
    logic [31:0] es, ef;
    got = {DMem_Req, PC_Write, IF_ID_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Redirect, Fault};
    exp = expect_vec();
    es  = (PERF && !Rst) ? mdl_stall[31:0] : 32'd0;
    ef  = (PERF && !Rst) ? mdl_flush[31:0] : 32'd0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ctrl_vec t=%0t got=%b exp=%b", $time, got, exp);
    end
    checks++;
    if (StallCycles !== es || FlushCount !== ef) begin
      errors++;
      $display("FAIL counters t=%0t got=%0d/%0d exp=%0d/%0d",
               $time, StallCycles, FlushCount, es, ef);
    end
  end

  task automatic pin(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic acc, input logic rdy,
                       input logic br, input logic jmp, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur);
    @(posedge Clk);
    #1;
    Rst             = rst;
    MEM_MemAccess   = acc;
    DMem_Ready      = rdy;
    MEM_BranchTaken = br;
    MEM_Jump        = jmp;
    EX_MemRead      = mr;
    EX_Rd           = rd;
    ID_Rs           = rs;
    ID_Rt           = rt;
    ID_UsesRt       = ur;
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic mreq(input logic rdy);
    drive(0, 1, rdy, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    Rst = 1'b1;
    MEM_MemAccess = 0; DMem_Ready = 0; MEM_BranchTaken = 0; MEM_Jump = 0;
    EX_MemRead = 0; EX_Rd = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0;

    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    pin("rst_pcw", PC_Write, 0);
    pin("rst_ifidf", IF_ID_Flush, 1);
    pin("rst_fault", Fault, 0);

    idle();
    pin("idle_pcw", PC_Write, 1);
    pin("idle_req", DMem_Req, 0);

    drive(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    pin("lu_pcw", PC_Write, 0);
    pin("lu_ifidw", IF_ID_Write, 0);
    pin("lu_idexf", ID_EX_Flush, 1);
    pin("lu_memwb", MEM_WB_Write, 1);
    idle();
    pin("lu_once", PC_Write, 1);

    drive(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    pin("lu_r0", PC_Write, 1);
    drive(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
    pin("lu_rt_unused", PC_Write, 1);
    drive(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
    pin("lu_rt_used", PC_Write, 0);

    drive(0, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    pin("br_redir", Redirect, 1);
    pin("br_ifidf", IF_ID_Flush, 1);
    pin("br_exmemf", EX_MEM_Flush, 1);
    pin("br_pcw", PC_Write, 1);
    pin("br_ifidw", IF_ID_Write, 1);
    idle();
    pin("br_done", Redirect, 0);
    pin("flushcnt", FlushCount, PERF ? 1 : 0);

    mreq(0);
    pin("mw_req", DMem_Req, 1);
    pin("mw_pcw", PC_Write, 0);
    pin("mw_memwb", MEM_WB_Write, 0);
    mreq(0);
    mreq(0);
    mreq(1);
    pin("mw_rel_pcw", PC_Write, 1);
    pin("mw_rel_req", DMem_Req, 1);
    idle();
    pin("mw_run", DMem_Req, 0);
    pin("stallcnt", StallCycles, PERF ? 5 : 0);

    drive(0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    pin("m0_redir", Redirect, 1);
    drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    pin("mbr_hold", Redirect, 0);
    pin("mbr_noflush", IF_ID_Flush, 0);
    drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    pin("mbr_late", Redirect, 1);

    mreq(0);
    mreq(0);
    drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    pin("rst_wait_req", DMem_Req, 0);
    idle();
    pin("rst_wait_run", DMem_Req, 0);

    mreq(0);
    mreq(0);
    mreq(0);
    mreq(0);
    mreq(0);
    pin("to_last_wait", Fault, 0);
    mreq(1);
    pin("to_fault", Fault, 1);
    pin("to_req", DMem_Req, 0);
    pin("to_pcw", PC_Write, 0);
    idle();
    pin("to_sticky", Fault, 1);
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle();
    pin("to_clear", Fault, 0);
    pin("to_run_pcw", PC_Write, 1);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
